pipemdu: RTL

PIPEMDU -- requirements
Module: pipemdu

---
 rtl/pipemdu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipemdu.sv
// Iterative multiply/divide unit for the EXE stage: 32-step shift-add multiply and restoring divide, HI/LO registers.
// Define MDU_DIV_EN to build the divider datapath and DIV state; without it div/divu behave as no-ops.
module pipemdu (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [2:0]  emduop,
    input  logic        estart,
    input  logic        eflush,
    output logic        ebusy,
    output logic [31:0] ehi,
    output logic [31:0] elo
);

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_neg;

    logic        w_go;
    logic        w_is_mul;
    logic        w_signed;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_msum;
    logic [63:0] w_fix;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_go     = estart && !eflush && (r_state == S_IDLE);
    assign w_is_mul = (emduop == 3'b001) || (emduop == 3'b010);
    assign w_signed = (emduop == 3'b001) || (emduop == 3'b011);
    assign w_sa     = w_signed && ea[31];
    assign w_sb     = w_signed && eb[31];
    assign w_mag_a  = w_sa ? (32'd0 - ea) : ea;
    assign w_mag_b  = w_sb ? (32'd0 - eb) : eb;

    // Multiply: low half of r_acc holds the remaining multiplier bits, high half accumulates.
    assign w_msum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_a : 32'd0)};
    assign w_fix    = r_neg ? (64'd0 - r_acc) : r_acc;

`ifdef MDU_DIV_EN
    logic        w_is_div;
    logic        r_div;
    logic        r_neg_rem;
    logic [32:0] w_dshift;
    logic [31:0] w_dsub;
    logic        w_dge;
    logic [31:0] w_drem;

    assign w_is_div = (emduop == 3'b011) || (emduop == 3'b100);
    // Divide: r_acc = {remainder, dividend/quotient}; the trial difference fits 32 bits whenever it is kept.
    assign w_dshift = {r_acc[63:32], r_acc[31]};
    assign w_dge    = (w_dshift >= {1'b0, r_a});
    assign w_dsub   = w_dshift[31:0] - r_a;
    assign w_drem   = w_dge ? w_dsub : w_dshift[31:0];

    always_comb begin
        w_fix_hi = w_fix[63:32];
        w_fix_lo = w_fix[31:0];
        if (r_div) begin
            w_fix_lo = r_neg     ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
            w_fix_hi = r_neg_rem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        end
    end
`else
    assign w_fix_hi = w_fix[63:32];
    assign w_fix_lo = w_fix[31:0];
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (eflush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (estart && w_is_mul) w_next = S_MUL;
`ifdef MDU_DIV_EN
                    else if (estart && w_is_div) w_next = S_DIV;
`endif
                end
                S_MUL:   if (r_cnt == 5'd31) w_next = S_FIX;
`ifdef MDU_DIV_EN
                S_DIV:   if (r_cnt == 5'd31) w_next = S_FIX;
`endif
                S_FIX:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ebusy = (r_state != S_IDLE);
        ehi   = r_hi;
        elo   = r_lo;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_a   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
`ifdef MDU_DIV_EN
            r_div     <= 1'b0;
            r_neg_rem <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cnt <= '0;
                        if (w_is_mul) begin
                            r_a   <= w_mag_a;
                            r_acc <= {32'd0, w_mag_b};
                            r_neg <= w_sa ^ w_sb;
`ifdef MDU_DIV_EN
                            r_div <= 1'b0;
                        end else if (w_is_div) begin
                            // Zero divisor keeps the all-ones quotient; remainder sign still restores ea.
                            r_a       <= w_mag_b;
                            r_acc     <= {32'd0, w_mag_a};
                            r_neg     <= (w_sa ^ w_sb) && (eb != 32'd0);
                            r_neg_rem <= w_sa;
                            r_div     <= 1'b1;
`endif
                        end else if (emduop == 3'b101) begin
                            r_hi <= ea;
                        end else if (emduop == 3'b110) begin
                            r_lo <= ea;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_msum, r_acc[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    r_acc <= {w_drem, r_acc[30:0], w_dge};
                    r_cnt <= r_cnt + 5'd1;
                end
`endif
                S_FIX: begin
                    if (!eflush) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
